// File: rtl/mul_rnd_pipe.sv
// Two-stage valid/ready rounding stage for the FP multiplier: S1 decides the round-up carry,
// S2 increments, renormalises and flags overflow. Optional flush port under MUL_RND_FLUSH_EN.
module mul_rnd_pipe #(
  parameter int unsigned EXPO_W = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef MUL_RND_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sign_in,
  input  logic [2*MANT_W+1:0] mant_in,
  input  logic [EXPO_W+1:0]   expo_in,
  input  logic                sticky_in,
  input  logic [2:0]          rnd_in,
  input  logic                a_is_n0,
  input  logic                b_is_n0,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sign_out,
  output logic [EXPO_W+1:0]   expo_out,
  output logic [MANT_W-1:0]   mant_out,
  output logic                inexact_out,
  output logic                ovf_out
);

  localparam int unsigned EW = EXPO_W + 2;
  localparam int unsigned UW = MANT_W + 2;
  localparam logic [EXPO_W:0] OvfThr = {1'b0, {EXPO_W{1'b1}}};

  typedef enum logic [2:0] {
    RndRne = 3'b000,
    RndRtz = 3'b001,
    RndRdn = 3'b010,
    RndRup = 3'b011,
    RndRmm = 3'b100
  } rnd_e;

  logic flush_w;
`ifdef MUL_RND_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Handshake
  logic v1_q, v1_d, v2_q, v2_d;
  logic s1_adv, s2_adv, s1_load, s2_load;

  assign s2_adv   = !v2_q || out_ready;
  assign s1_adv   = !v1_q || s2_adv;
  assign in_ready = s1_adv && !flush_w;
  assign s1_load  = in_ready && in_valid;
  assign s2_load  = s2_adv && v1_q && !flush_w;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (flush_w) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (s2_adv) v2_d = v1_q;
      if (s1_adv) v1_d = in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  // S1: guard/round/sticky extraction and carry decision
  logic g_bit, r_bit, s_bit, nz, carry;
  rnd_e rnd;

  assign g_bit = mant_in[MANT_W];
  assign r_bit = mant_in[MANT_W-1];
  assign s_bit = (|mant_in[MANT_W-2:0]) | sticky_in;
  assign nz    = a_is_n0 & b_is_n0;
  assign rnd   = rnd_e'(rnd_in);

  always_comb begin
    carry = 1'b0;
    case (rnd)
      RndRtz:  carry = 1'b0;
      RndRdn:  carry = sign_in & nz & (r_bit | s_bit);
      RndRup:  carry = !sign_in & nz & (r_bit | s_bit);
      RndRmm:  carry = r_bit & nz;
      default: carry = r_bit & (g_bit | s_bit);
    endcase
  end

  logic          sign1_q;
  logic [UW-1:0] upper1_q;
  logic [EW-1:0] expo1_q;
  logic          carry1_q;
  logic          inexact1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign1_q    <= 1'b0;
      upper1_q   <= '0;
      expo1_q    <= '0;
      carry1_q   <= 1'b0;
      inexact1_q <= 1'b0;
    end else if (s1_load) begin
      sign1_q    <= sign_in;
      upper1_q   <= mant_in[2*MANT_W+1:MANT_W];
      expo1_q    <= expo_in;
      carry1_q   <= carry;
      inexact1_q <= r_bit | s_bit;
    end
  end

  // S2: increment, renormalise; a zero exponent with a carry into the hidden bit is promoted
  logic [UW-1:0]     m_sum;
  logic              expo_inc;
  logic [EW-1:0]     expo_nxt;
  logic [MANT_W-1:0] mant_nxt;
  logic              ovf_nxt;

  always_comb begin
    m_sum    = upper1_q + {{(UW-1){1'b0}}, carry1_q};
    expo_inc = m_sum[MANT_W+1] | ((expo1_q == '0) & m_sum[MANT_W]);
    expo_nxt = expo1_q + {{(EW-1){1'b0}}, expo_inc};
    mant_nxt = m_sum[MANT_W+1] ? m_sum[MANT_W:1] : m_sum[MANT_W-1:0];
    ovf_nxt  = !expo_nxt[EW-1] && (expo_nxt[EXPO_W:0] >= OvfThr);
  end

  logic              sign2_q;
  logic [EW-1:0]     expo2_q;
  logic [MANT_W-1:0] mant2_q;
  logic              inexact2_q;
  logic              ovf2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign2_q    <= 1'b0;
      expo2_q    <= '0;
      mant2_q    <= '0;
      inexact2_q <= 1'b0;
      ovf2_q     <= 1'b0;
    end else if (s2_load) begin
      sign2_q    <= sign1_q;
      expo2_q    <= expo_nxt;
      mant2_q    <= mant_nxt;
      inexact2_q <= inexact1_q;
      ovf2_q     <= ovf_nxt;
    end
  end

  assign out_valid   = v2_q;
  assign sign_out    = sign2_q;
  assign expo_out    = expo2_q;
  assign mant_out    = mant2_q;
  assign inexact_out = inexact2_q;
  assign ovf_out     = ovf2_q;

endmodule
